// File: rtl/dcpu_bus_pkg.sv
// Shared constants for the dcpu bus responder: MMIO word offsets, CTRL/STATUS
// bit positions and the read-only ID value.
package dcpu_bus_pkg;

    localparam logic [2:0] REG_CTRL   = 3'd0;
    localparam logic [2:0] REG_STATUS = 3'd1;
    localparam logic [2:0] REG_RELOAD = 3'd2;
    localparam logic [2:0] REG_COUNT  = 3'd3;
    localparam logic [2:0] REG_PRESC  = 3'd4;
    localparam logic [2:0] REG_ID     = 3'd5;

    localparam int CTRL_EN  = 0;
    localparam int CTRL_AR  = 1;
    localparam int CTRL_IRQ = 2;

    localparam int ST_EXP = 0;
    localparam int ST_WP  = 1;

    localparam logic [15:0] DCPU_BUS_ID = 16'hDC01;

endpackage

// File: rtl/dcpu_timer.sv
// Prescaled down-counting timer: owns CTRL, RELOAD, COUNT, PRESC and the
// prescaler; reports a one-cycle expire strobe for the STATUS register.
module dcpu_timer
    import dcpu_bus_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        wr_ctrl_i,
    input  logic        wr_reload_i,
    input  logic        wr_count_i,
    input  logic        wr_presc_i,
    input  logic [15:0] wdata_i,
    output logic [2:0]  ctrl_o,
    output logic [15:0] reload_o,
    output logic [15:0] count_o,
    output logic [15:0] presc_o,
    output logic        expire_o
);

    logic [2:0]  ctrl_q, ctrl_d;
    logic [15:0] reload_q, reload_d;
    logic [15:0] count_q, count_d;
    logic [15:0] presc_q, presc_d;
    logic [15:0] psc_q, psc_d;
    logic        tick;

    always_comb begin
        tick     = ctrl_q[CTRL_EN] && (psc_q == presc_q);
        expire_o = tick && (count_q == 16'd1);

        psc_d = psc_q + 16'd1;
        if (!ctrl_q[CTRL_EN] || wr_ctrl_i || wr_presc_i || tick)
            psc_d = '0;

        // A tick that finds COUNT at 1 or 0 without auto-reload stops the
        // timer; this wins over a CPU write of en=1 on the same edge.
        ctrl_d = wr_ctrl_i ? wdata_i[2:0] : ctrl_q;
        if (tick && !ctrl_q[CTRL_AR] && (count_q <= 16'd1))
            ctrl_d[CTRL_EN] = 1'b0;

        count_d = count_q;
        if (tick) begin
            if (count_q > 16'd1)      count_d = count_q - 16'd1;
            else if (ctrl_q[CTRL_AR]) count_d = reload_q;
            else                      count_d = '0;
        end
        if (wr_count_i)
            count_d = wdata_i;

        reload_d = wr_reload_i ? wdata_i : reload_q;
        presc_d  = wr_presc_i  ? wdata_i : presc_q;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            ctrl_q   <= '0;
            reload_q <= '0;
            count_q  <= '0;
            presc_q  <= '0;
            psc_q    <= '0;
        end else begin
            ctrl_q   <= ctrl_d;
            reload_q <= reload_d;
            count_q  <= count_d;
            presc_q  <= presc_d;
            psc_q    <= psc_d;
        end
    end

    assign ctrl_o   = ctrl_q;
    assign reload_o = reload_q;
    assign count_o  = count_q;
    assign presc_o  = presc_q;

endmodule

// File: rtl/dcpu_bus_responder.sv
// dcpu memory-side responder: mirrored word RAM plus an 8-word MMIO timer window.
// Optional low-memory write protection is enabled with `DCPU_BUS_WPROT_EN.
module dcpu_bus_responder
    import dcpu_bus_pkg::*;
#(
    parameter int          RAM_AW    = 12,
    parameter logic [15:0] MMIO_BASE = 16'hFF00,
    parameter logic [15:0] WPROT_TOP = 16'h0100,
    parameter              INIT_FILE = ""
) (
    input  logic        i_clk,
    input  logic        i_reset_n,
    input  logic [15:0] i_addr,
    input  logic [15:0] i_dat,
    input  logic        i_rw,
    output logic [15:0] o_dat,
    output logic        o_int
);

    logic [15:0]       mem_q [0:(1<<RAM_AW)-1];
    logic [RAM_AW-1:0] ram_idx;
    logic              mmio, mmio_we, ram_we, wp_block;
    logic [2:0]        off;
    logic [2:0]        ctrl;
    logic [15:0]       reload, count, presc;
    logic              expire;
    logic              expired_q, expired_d;
    logic              wp_err_q, wp_err_d;
    logic              unused_a0;

    assign mmio      = (i_addr[15:4] == MMIO_BASE[15:4]);
    assign off       = i_addr[3:1];
    assign ram_idx   = i_addr[RAM_AW:1];
    assign mmio_we   = !i_rw && mmio;
    assign unused_a0 = i_addr[0];

`ifdef DCPU_BUS_WPROT_EN
    assign wp_block = !i_rw && !mmio && (i_addr < WPROT_TOP);
`else
    logic [15:0] unused_wprot;
    assign unused_wprot = WPROT_TOP;
    assign wp_block     = 1'b0;
`endif

    assign ram_we = !i_rw && !mmio && !wp_block;

    // RAM is not reset; a write coinciding with reset assertion is dropped.
    always_ff @(posedge i_clk) begin
        if (i_reset_n && ram_we)
            mem_q[ram_idx] <= i_dat;
    end

    dcpu_timer u_timer (
        .clk_i       (i_clk),
        .rst_n_i     (i_reset_n),
        .wr_ctrl_i   (mmio_we && (off == REG_CTRL)),
        .wr_reload_i (mmio_we && (off == REG_RELOAD)),
        .wr_count_i  (mmio_we && (off == REG_COUNT)),
        .wr_presc_i  (mmio_we && (off == REG_PRESC)),
        .wdata_i     (i_dat),
        .ctrl_o      (ctrl),
        .reload_o    (reload),
        .count_o     (count),
        .presc_o     (presc),
        .expire_o    (expire)
    );

    // STATUS is write-one-to-clear; a hardware set on the same edge wins.
    always_comb begin
        expired_d = expired_q;
        if (mmio_we && (off == REG_STATUS) && i_dat[ST_EXP]) expired_d = 1'b0;
        if (expire) expired_d = 1'b1;

        wp_err_d = wp_err_q;
        if (mmio_we && (off == REG_STATUS) && i_dat[ST_WP]) wp_err_d = 1'b0;
        if (wp_block) wp_err_d = 1'b1;
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            expired_q <= 1'b0;
            wp_err_q  <= 1'b0;
        end else begin
            expired_q <= expired_d;
            wp_err_q  <= wp_err_d;
        end
    end

    always_comb begin
        o_dat = mem_q[ram_idx];
        if (mmio) begin
            case (off)
                REG_CTRL:   o_dat = {13'd0, ctrl};
                REG_STATUS: o_dat = {14'd0, wp_err_q, expired_q};
                REG_RELOAD: o_dat = reload;
                REG_COUNT:  o_dat = count;
                REG_PRESC:  o_dat = presc;
                REG_ID:     o_dat = DCPU_BUS_ID;
                default:    o_dat = '0;
            endcase
        end
    end

    assign o_int = expired_q && ctrl[CTRL_IRQ];

endmodule
